// File: rtl/id_issue_ctrl.sv
// Decode-stage sequencer: owns the IF/ID register, detects load-use hazards
// against EX, squashes on branch flush and keeps saturating stall/flush counters.
module id_issue_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      if_instr_i,
  input  logic [31:0]      if_pc_i,
  input  logic             if_valid_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             flush_i,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic             id_valid_o,
  output logic             stall_if_o,
  output logic             bubble_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [6:0] {
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_REG    = 7'b0110011
  } opcode_e;

  logic       uses_rs1;
  logic       uses_rs2;
  logic       supported;
  logic       hazard;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign rs1 = id_instr_o[19:15];
  assign rs2 = id_instr_o[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    supported = 1'b0;
    case (id_instr_o[6:0])
      OP_IMM, OP_LOAD: begin
        uses_rs1  = 1'b1;
        supported = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        supported = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard = id_valid_o & ex_is_load_i & (ex_rd_i != 5'd0) &
             ((uses_rs1 & (rs1 == ex_rd_i)) | (uses_rs2 & (rs2 == ex_rd_i)));
  end

  // Reset overrides the flow-control outputs so nothing upstream stalls while the core is held.
  always_comb begin
    stall_if_o = 1'b0;
    bubble_o   = 1'b1;
    illegal_o  = 1'b0;
    if (!rst_i) begin
      stall_if_o = hazard & ~flush_i;
      bubble_o   = hazard | flush_i | ~id_valid_o;
      illegal_o  = id_valid_o & ~supported;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_valid_o <= 1'b0;
      id_instr_o <= NOP_INSTR;
      id_pc_o    <= '0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
      id_instr_o <= NOP_INSTR;
    end else if (!hazard) begin
      id_valid_o <= if_valid_i;
      id_instr_o <= if_valid_i ? if_instr_i : NOP_INSTR;
      id_pc_o    <= if_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Decode-stage sequencer for the pipelined RV32 core.
- Owns the IF/ID pipeline register that feeds the immediate generator and the main decoder.
- Detects load-use hazards against the instruction in EX, then stalls fetch and injects a bubble into ID/EX.
- Squashes wrong-path instructions on a branch flush and keeps saturating stall/flush performance counters.

Parameters:
- NOP_INSTR, 32'h00000013, instruction driven on id_instr_o when IF/ID is empty (addi x0,x0,0, so the immediate is 0).
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_instr_i  in  32  fetched instruction.
- if_pc_i  in  32  PC of the fetched instruction.
- if_valid_i  in  1  fetched instruction is valid this cycle.
- ex_is_load_i  in  1  instruction currently in EX is a load (opcode 0000011).
- ex_rd_i  in  5  destination register of the instruction in EX.
- flush_i  in  1  branch resolved taken in EX; younger instructions are wrong-path.
- id_instr_o  out  32  IF/ID instruction, to immediate generator and decoder.
- id_pc_o  out  32  IF/ID PC.
- id_valid_o  out  1  IF/ID holds a live instruction.
- stall_if_o  out  1  hold PC and fetch this cycle.
- bubble_o  out  1  load a NOP into ID/EX this cycle.
- illegal_o  out  1  live ID instruction has an unsupported opcode.
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt_o  out  CNT_W  flush events, saturating.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values: id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=0, counters 0.
- While rst_i=1: stall_if_o=0, bubble_o=1, illegal_o=0.
- Opcode decode, on id_instr_o[6:0]:
  - Supported opcodes: 0010011, 0000011, 0100011, 1100011, 0110011.
  - All five read rs1 = [19:15].
  - Only 0100011, 1100011 and 0110011 read rs2 = [24:20].
- hazard (combinational) = id_valid_o & ex_is_load_i & (ex_rd_i != 0) & ((uses_rs1 & rs1 == ex_rd_i) | (uses_rs2 & rs2 == ex_rd_i)).
- Combinational outputs:
  - stall_if_o = hazard & ~flush_i.
  - bubble_o = hazard | flush_i | ~id_valid_o.
  - illegal_o = id_valid_o & opcode not in the supported set.
- illegal_o has no effect on flow control.
- IF/ID register update, priority order:
  1. rst_i.
  2. flush_i: valid←0, instr←NOP_INSTR, pc unchanged.
  3. hazard: hold all fields.
  4. Otherwise: valid←if_valid_i; instr←if_valid_i ? if_instr_i : NOP_INSTR; pc←if_pc_i.
- Latency:
  - An instruction accepted at edge N appears on id_* immediately after edge N.
  - A load-use stall lasts exactly one cycle: the bubble clears the hazard in the next cycle, because EX then holds a NOP.
- Flush beats hazard in the same cycle: stall_if_o=0 and the ID instruction is killed.
- id_instr_o always equals NOP_INSTR whenever id_valid_o=0.
- Counters:
  - stall_cnt_o increments on each cycle with stall_if_o=1.
  - flush_cnt_o increments on each cycle with flush_i=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush: the state at the next edge equals the reset values above; no pending stall survives.
- ex_rd_i=0 never causes a hazard.

Test Plan:
- Reset, then idle (if_valid_i=0) → id_valid_o=0, id_instr_o=32'h00000013, bubble_o=1, stall_if_o=0, counters 0.
- if_instr_i=32'h00500093 (addi x1,x0,5), if_valid_i=1 at edge N → after N id_instr_o=32'h00500093, id_valid_o=1, bubble_o=0.
- ID=add x3,x1,x2 (32'h002081B3); EX load with ex_rd_i=1 → stall_if_o=1, bubble_o=1, ID held for 1 cycle. Next cycle ex_is_load_i=0 → advances; stall_cnt_o=1.
- Same ID instruction with ex_rd_i=0, and separately ID=addi x1,x2,4 with ex_rd_i=5 → no stall, no bubble.
- Hazard present with flush_i=1 in the same cycle → stall_if_o=0, bubble_o=1, next id_valid_o=0, id_instr_o=NOP_INSTR, flush_cnt_o=1.
- CNT_W=2, 5 consecutive hazard cycles forced (ex_is_load_i held) → stall_cnt_o saturates at 3. rst_i asserted mid-stall → all outputs return to reset values next edge.
